// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and types for the multi-digit 7-segment to
//            binary converter: segment patterns ({a,b,c,d,e,f,g}) for the
//            decimal digits and the converter state encoding.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}, bit 6 = a.
  localparam logic [6:0] SEG_0  = 7'b1111110;
  localparam logic [6:0] SEG_1  = 7'b0110000;
  localparam logic [6:0] SEG_2  = 7'b1101101;
  localparam logic [6:0] SEG_3  = 7'b1111001;
  localparam logic [6:0] SEG_4  = 7'b0110011;
  localparam logic [6:0] SEG_5  = 7'b1011011;
  localparam logic [6:0] SEG_6  = 7'b1011111;
  localparam logic [6:0] SEG_7  = 7'b1110010;
  localparam logic [6:0] SEG_7B = 7'b1110000;
  localparam logic [6:0] SEG_8  = 7'b1111111;
  localparam logic [6:0] SEG_9  = 7'b1111011;
  localparam logic [6:0] SEG_9B = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit_decode
// Purpose  : Combinational decode of one 7-segment pattern to a BCD digit.
//            Unknown patterns report o_hit=0 and o_digit=0.
// Ports    : i_seg   [6:0]  segment pattern {a,b,c,d,e,f,g}
//            o_hit          pattern found in the decode table
//            o_digit [3:0]  decoded digit (0 when o_hit=0)
// Revision : 1.0  initial release
// ============================================================================
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_hit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_hit   = 1'b1;
    o_digit = 4'd0;
    case (i_seg)
      SEG_0:          o_digit = 4'd0;
      SEG_1:          o_digit = 4'd1;
      SEG_2:          o_digit = 4'd2;
      SEG_3:          o_digit = 4'd3;
      SEG_4:          o_digit = 4'd4;
      SEG_5:          o_digit = 4'd5;
      SEG_6:          o_digit = 4'd6;
      SEG_7, SEG_7B:  o_digit = 4'd7;
      SEG_8:          o_digit = 4'd8;
      SEG_9, SEG_9B:  o_digit = 4'd9;
      default: begin
        o_hit   = 1'b0;
        o_digit = 4'd0;
      end
    endcase
  end

endmodule : seg7_digit_decode
`default_nettype wire

// File: rtl/seg7_multi_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : seg7_multi_to_bin
// Purpose  : Serially converts DIGITS captured 7-segment patterns into one
//            binary value (acc = acc*10 + digit, one digit per clock), with
//            valid/ready handshakes on both sides. Flags unknown patterns
//            (err) and results that do not fit in OUT_W bits (ovf).
// Config   : SEG7_MULTI_NEG_EN - when defined, dp of the most significant
//            digit is a minus sign and the result is two's complement.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready         input handshake
//            seg_in [8*DIGITS-1:0]     digit i at [8i+7:8i], MSB digit on top
//            out_valid/out_ready       output handshake
//            dec_out [OUT_W-1:0], err, ovf   result, held while out_valid
// Revision : 1.0  initial release
// ============================================================================
module seg7_multi_to_bin
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*DIGITS-1:0]   seg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      dec_out,
  output logic                  err,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int SR_W  = 8 * DIGITS;
  localparam int STP_W = OUT_W + 4;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SR_W-1:0]     r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_W-1:0]    r_acc;
  logic [OUT_W-1:0]    r_dec;
  logic                r_err;
  logic                r_ovf;

  logic                w_hit;
  logic [3:0]          w_digit;
  logic [STP_W-1:0]    w_step;
  logic [OUT_W-1:0]    w_acc_nxt;
  logic                w_carry;
  logic                w_last;
  logic [OUT_W-1:0]    w_result;
  logic                w_sign_ovf;

  // The most significant remaining digit always sits in the top byte.
  seg7_digit_decode u_dec (
    .i_seg   (r_shift[SR_W-2 -: 7]),
    .o_hit   (w_hit),
    .o_digit (w_digit)
  );

  // Extra 4 bits catch any carry out of OUT_W (10 < 16).
  assign w_step    = ({4'b0000, r_acc} * STP_W'(10)) + STP_W'(w_digit);
  assign w_acc_nxt = w_step[OUT_W-1:0];
  assign w_carry   = |w_step[STP_W-1:OUT_W];
  assign w_last    = (r_cnt == CNT_W'(1));

`ifdef SEG7_MULTI_NEG_EN
  localparam logic [OUT_W-1:0] c_HALF = {1'b1, {(OUT_W-1){1'b0}}};
  logic r_neg;

  // Magnitude 2**(OUT_W-1) is representable only as a negative value.
  assign w_sign_ovf = (w_acc_nxt > c_HALF) || ((w_acc_nxt == c_HALF) && !r_neg);
  assign w_result   = r_neg ? (~w_acc_nxt + OUT_W'(1)) : w_acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_neg <= seg_in[SR_W-1];
    end
  end
`else
  assign w_sign_ovf = 1'b0;
  assign w_result   = w_acc_nxt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CONV;
      end
      CONV: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_dec   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= seg_in;
            r_cnt   <= CNT_W'(DIGITS);
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        CONV: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << 8;
          r_cnt   <= r_cnt - CNT_W'(1);
          r_err   <= r_err | ~w_hit;
          if (w_last) begin
            r_dec <= w_result;
            r_ovf <= r_ovf | w_carry | w_sign_ovf;
          end else begin
            r_ovf <= r_ovf | w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_out = r_dec;
  assign err     = r_err;
  assign ovf     = r_ovf;

endmodule : seg7_multi_to_bin
`default_nettype wire

// File: tb/tb_seg7_multi_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_multi_to_bin
// Purpose  : Self-checking bench. Instance A: DIGITS=4, OUT_W=32.
//            Instance B: DIGITS=3, OUT_W=8 (modulo / overflow cases).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_multi_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [31:0] a_seg_in = '0, a_dec_out;
  logic        a_err, a_ovf;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [23:0] b_seg_in = '0;
  logic [7:0]  b_dec_out;
  logic        b_err, b_ovf;

  seg7_multi_to_bin #(.DIGITS(4), .OUT_W(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .seg_in(a_seg_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .dec_out(a_dec_out), .err(a_err), .ovf(a_ovf)
  );

  seg7_multi_to_bin #(.DIGITS(3), .OUT_W(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .seg_in(b_seg_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dec_out(b_dec_out), .err(b_err), .ovf(b_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference patterns, index = digit value (10, 11 are the alternate 7 and 9).
  logic [6:0] pat [12] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                           7'b1111111, 7'b1111011, 7'b1110000, 7'b1110011};
  int         pval [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 7, 9};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 12; i++) if (pat[i] == p) return pval[i];
    return -1;
  endfunction

  // Behavioural model: decimal value of the word, then range checks.
  function automatic void model(input logic [31:0] word, input int nd, input int ow,
                                output logic [31:0] val, output logic e, output logic o);
    longint unsigned v = 0;
    longint unsigned lim = 64'd1 << ow;
    logic neg = word[8*nd-1];
    int d;
    e = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = lookup(word[8*i +: 7]);
      if (d < 0) begin e = 1'b1; d = 0; end
      v = v * 10 + longint'(d);
    end
    o = (v >= lim);
`ifdef SEG7_MULTI_NEG_EN
    if (v > lim / 2 || (v == lim / 2 && !neg)) o = 1'b1;
    if (neg) v = -v;
`else
    if (neg) o = o;
`endif
    val = 32'(v & (lim - 1));
  endfunction

  function automatic logic [7:0] rand_digit_byte();
    logic [6:0] p;
    if ($urandom_range(0, 7) == 0) begin
      p = 7'h00;
      for (int t = 0; t < 200; t++) begin
        p = 7'($urandom_range(0, 127));
        if (lookup(p) < 0) break;
      end
    end else begin
      p = pat[$urandom_range(0, 11)];
    end
    return {1'($urandom_range(0, 1)), p};
  endfunction

  // Drive one word into instance sel (0=A, 1=B) and check the full transaction.
  task automatic run_word(input bit sel, input logic [31:0] word, input logic [31:0] ev,
                          input logic ee, input logic eo, input string tag);
    int nd = sel ? 3 : 4;
    int lat = 0;
    @(negedge clk);
    check({tag, ".in_ready"}, sel ? b_in_ready : a_in_ready, 1);
    if (sel) begin b_in_valid = 1'b1; b_seg_in = word[23:0]; end
    else     begin a_in_valid = 1'b1; a_seg_in = word; end
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if ((sel ? b_out_valid : a_out_valid) == 1'b1) break;
      @(posedge clk); #1;
      if ((sel ? b_out_valid : a_out_valid) == 1'b1) begin lat = k; break; end
    end
    check({tag, ".latency"}, lat, nd);
    check({tag, ".dec_out"}, sel ? {24'h0, b_dec_out} : a_dec_out, ev);
    check({tag, ".err"}, sel ? b_err : a_err, ee);
    check({tag, ".ovf"}, sel ? b_ovf : a_ovf, eo);
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, sel ? b_out_valid : a_out_valid, 0);
  endtask

  function automatic logic [31:0] w4(input int d3, input int d2, input int d1, input int d0);
    return {1'b0, pat[d3], 1'b0, pat[d2], 1'b0, pat[d1], 1'b0, pat[d0]};
  endfunction

  initial begin
    logic [31:0] w, ev, hold_v;
    logic ee, eo;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", a_in_ready, 1);
    check("reset.out_valid", a_out_valid, 0);
    check("reset.dec_out", a_dec_out, 0);
    check("reset.err", a_err, 0);
    check("reset.ovf", a_ovf, 0);
    check("reset.b_out_valid", b_out_valid, 0);

    // 1) 1234
    run_word(0, w4(1, 2, 3, 4), 32'd1234, 0, 0, "t1_1234");

    // 2) invalid pattern in digit 1, 7 in LSB
    w = {1'b0, pat[0], 1'b0, pat[0], 8'b0000_0001, 1'b0, pat[7]};
    run_word(0, w, 32'd7, 1, 0, "t2_err");

    // 3) narrow instance: modulo wrap and boundary
    run_word(1, {8'h0, 1'b0, pat[9], 1'b0, pat[9], 1'b0, pat[9]}, 32'd231, 0, 1, "t3_999");
    run_word(1, {8'h0, 1'b0, pat[2], 1'b0, pat[5], 1'b0, pat[5]}, 32'd255, 0, 0, "t3_255");

    // 4) back-pressure in DONE; a new in_valid must be ignored
    w = w4(5, 6, 7, 8);
    @(negedge clk); a_in_valid = 1'b1; a_seg_in = w;
    @(posedge clk); #1; a_in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin @(posedge clk); #1; seen = a_out_valid; end
    check("t4.reach_done", seen, 1);
    hold_v = a_dec_out;
    check("t4.value", hold_v, 32'd5678);
    a_in_valid = 1'b1; a_seg_in = w4(9, 9, 9, 9);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t4.hold_valid", a_out_valid, 1);
      check("t4.hold_value", a_dec_out, 32'd5678);
      check("t4.hold_in_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1; a_out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 7; k++) begin @(posedge clk); #1; seen = seen | a_out_valid; end
    check("t4.ignored_word", seen, 0);

    // 5) reset pulse on the 2nd CONV cycle discards the word
    @(negedge clk); a_in_valid = 1'b1; a_seg_in = w4(3, 3, 3, 3);
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1; #2 rst = 1'b0;
    #1;
    check("t5.dec_out_reset", a_dec_out, 0);
    check("t5.in_ready", a_in_ready, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; seen = seen | a_out_valid; end
    check("t5.no_output", seen, 0);
    run_word(0, w4(0, 0, 4, 2), 32'd42, 0, 0, "t5_0042");

    // 6) minus sign on the MSB digit dp
    w = w4(0, 0, 4, 2); w[31] = 1'b1;
`ifdef SEG7_MULTI_NEG_EN
    run_word(0, w, 32'hFFFF_FFD6, 0, 0, "t6_neg");
`else
    run_word(0, w, 32'd42, 0, 0, "t6_neg");
`endif

    // Randomized words against the model
    for (int n = 0; n < 24; n++) begin
      w = {rand_digit_byte(), rand_digit_byte(), rand_digit_byte(), rand_digit_byte()};
      model(w, 4, 32, ev, ee, eo);
      run_word(0, w, ev, ee, eo, "rand_a");
    end
    for (int n = 0; n < 16; n++) begin
      w = {8'h00, rand_digit_byte(), rand_digit_byte(), rand_digit_byte()};
      model(w, 3, 8, ev, ee, eo);
      run_word(1, w, ev, ee, eo, "rand_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule : tb_seg7_multi_to_bin
`default_nettype wire
